// File: rtl/hex_scan_pkg.sv
// Shared constants and scan-state encoding for the multiplexed seven-segment scheduler.
package hex_scan_pkg;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam int         NUM_DIGITS = 4;
    localparam int         PTR_W      = 2;
    localparam int         BCD_W      = 4;

    // One state per digit; the encoding doubles as the scan pointer.
    typedef enum logic [PTR_W-1:0] {S0, S1, S2, S3} scan_state_t;
endpackage

// File: rtl/dec_to_hex.sv
// BCD to active-low seven-segment decoder, bit 6 = g. Non-decimal codes blank the digit.
module dec_to_hex
    import hex_scan_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0011000;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/hex_scan_scheduler.sv
// Four BCD digit registers scanned round-robin through one shared decoder into
// registered HEX0..HEX3 outputs, with leading-zero blanking, scan hold and frame pulse.
module hex_scan_scheduler
    import hex_scan_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       blank_lz,
    input  logic       hold,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic       frame_done,
    output logic [1:0] cur_digit
);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);

    logic [BCD_W-1:0] digit [NUM_DIGITS];
    logic [6:0]       hex_q [NUM_DIGITS];
    logic [CNT_W-1:0] div;
    scan_state_t      state, state_nxt;
    logic [PTR_W-1:0] ptr;
    logic             tick;
    logic             blank3, blank2, blank1, blank_cur;
    logic [6:0]       dec_seg, seg;

    assign ptr  = state;
    assign tick = (div == DIV_LAST) && !hold;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
        end else if (wr_en) begin
            digit[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset)      div <= '0;
        else if (!hold) div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= S0;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                S0: state_nxt = S1;
                S1: state_nxt = S2;
                S2: state_nxt = S3;
                S3: state_nxt = S0;
                default: state_nxt = S0;
            endcase
        end
    end

    // Blanking chains downward from the most significant digit; units never blank.
    assign blank3 = blank_lz && (digit[3] == '0);
    assign blank2 = blank3 && (digit[2] == '0);
    assign blank1 = blank2 && (digit[1] == '0);

    always_comb begin
        blank_cur = 1'b0;
        case (ptr)
            2'd3: blank_cur = blank3;
            2'd2: blank_cur = blank2;
            2'd1: blank_cur = blank1;
            default: blank_cur = 1'b0;
        endcase
    end

    dec_to_hex u_dec (
        .bcd (digit[ptr]),
        .seg (dec_seg)
    );

    assign seg = blank_cur ? SEG_BLANK : dec_seg;

    // Only the slot being closed is loaded, so a same-cycle write shows next visit.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tick && (state == S3);
            if (tick) hex_q[ptr] <= seg;
        end
    end

    assign HEX0      = hex_q[0];
    assign HEX1      = hex_q[1];
    assign HEX2      = hex_q[2];
    assign HEX3      = hex_q[3];
    assign cur_digit = ptr;
endmodule

// File: tb/tb_hex_scan_scheduler.sv
// Directed bench: dut_a scans every cycle (SCAN_DIV=1), dut_b every third cycle; inputs shared.
module tb_hex_scan_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       blank_lz = 1'b0;
    logic       hold = 1'b0;
    logic [6:0] ha0, ha1, ha2, ha3, hb0, hb1, hb2, hb3;
    logic       fda, fdb;
    logic [1:0] cda, cdb;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] D0  = 7'b1000000;

    always #5 clk = ~clk;

    hex_scan_scheduler #(.SCAN_DIV(1), .CNT_W(2)) dut_a (
        .CLOCK_50(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .blank_lz(blank_lz), .hold(hold), .HEX0(ha0), .HEX1(ha1), .HEX2(ha2), .HEX3(ha3),
        .frame_done(fda), .cur_digit(cda)
    );

    hex_scan_scheduler #(.SCAN_DIV(3), .CNT_W(2)) dut_b (
        .CLOCK_50(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .blank_lz(blank_lz), .hold(hold), .HEX0(hb0), .HEX1(hb1), .HEX2(hb2), .HEX3(hb3),
        .frame_done(fdb), .cur_digit(cdb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step(1);
        wr_en = 1'b0;
    endtask

    initial begin
        #1;
        // Reset and first frame
        step(1);
        chk("rst_a_hex0", ha0, BLK); chk("rst_a_hex3", ha3, BLK);
        chk("rst_b_hex1", hb1, BLK); chk("rst_b_hex2", hb2, BLK);
        chk("rst_a_ptr", cda, 0);    chk("rst_a_fd", fda, 0);
        reset = 1'b0;
        step(3);
        chk("f1_a_hex0", ha0, D0); chk("f1_a_hex3_pre", ha3, BLK); chk("f1_a_fd_pre", fda, 0);
        step(1);
        chk("f1_a_hex1", ha1, D0); chk("f1_a_hex2", ha2, D0); chk("f1_a_hex3", ha3, D0);
        chk("f1_a_fd", fda, 1);    chk("f1_a_ptr_wrap", cda, 0);
        step(1);
        chk("f1_a_fd_clear", fda, 0);
        chk("f1_b_hex0", hb0, D0); chk("f1_b_hex1", hb1, BLK); chk("f1_b_ptr", cdb, 1);

        // Writes and latency on the SCAN_DIV=3 instance
        reset = 1'b1; step(1);
        reset = 1'b0; hold = 1'b1;
        wr(0, 4'd6); wr(1, 4'd2); wr(2, 4'd5); wr(3, 4'd6);
        hold = 1'b0;
        step(2);
        chk("wr_b_hex0_pre", hb0, BLK);
        step(1);
        chk("wr_b_hex0", hb0, 7'b0000010); chk("wr_b_hex1_pre", hb1, BLK); chk("wr_b_ptr", cdb, 1);
        step(9);
        chk("wr_b_hex1", hb1, 7'b0100100); chk("wr_b_hex2", hb2, 7'b0010010);
        chk("wr_b_hex3", hb3, 7'b0000010); chk("wr_b_ptr_end", cdb, 0);

        // Leading-zero blanking
        hold = 1'b1; blank_lz = 1'b1;
        wr(1, 4'd7); wr(0, 4'd0); wr(2, 4'd0); wr(3, 4'd0);
        hold = 1'b0;
        step(12);
        chk("lz_hex3", hb3, BLK); chk("lz_hex2", hb2, BLK);
        chk("lz_hex1", hb1, 7'b1111000); chk("lz_hex0", hb0, D0);
        hold = 1'b1; wr(1, 4'd0); hold = 1'b0;
        step(12);
        chk("lz0_hex1", hb1, BLK); chk("lz0_hex3", hb3, BLK); chk("lz0_hex0", hb0, D0);
        blank_lz = 1'b0;

        // Write/tick collision on the every-cycle instance
        reset = 1'b1; step(1);
        reset = 1'b0; hold = 1'b1;
        wr(1, 4'd3);
        hold = 1'b0;
        step(1);
        chk("col_ptr1", cda, 1);
        wr(1, 4'd9);
        chk("col_old", ha1, 7'b0110000); chk("col_ptr2", cda, 2);
        step(3);
        chk("col_hold_old", ha1, 7'b0110000);
        step(1);
        chk("col_new", ha1, 7'b0011000);

        // Hold at ptr=2 with a write underneath
        reset = 1'b1; step(1);
        reset = 1'b0;
        step(7);
        chk("hold_ptr_entry", cdb, 2);
        hold = 1'b1;
        wr(2, 4'd8);
        chk("hold_fd_0", fdb, 0);
        for (int i = 1; i < 20; i++) begin
            step(1);
            chk("hold_fd", fdb, 0);
        end
        chk("hold_ptr", cdb, 2); chk("hold_hex2", hb2, BLK);
        hold = 1'b0;
        step(1);
        chk("rel_hex2_pre", hb2, BLK); chk("rel_ptr_pre", cdb, 2);
        step(1);
        chk("rel_hex2", hb2, 7'b0000000); chk("rel_ptr", cdb, 3);

        // Invalid BCD and reset mid-frame
        wr(0, 4'hC);
        step(1);
        chk("inv_fd_pre", fdb, 0);
        step(1);
        chk("inv_fd", fdb, 1); chk("inv_ptr", cdb, 0); chk("inv_hex0_old", hb0, D0);
        step(2);
        chk("inv_hex0_still", hb0, D0);
        step(1);
        chk("inv_hex0", hb0, BLK); chk("inv_ptr1", cdb, 1);
        step(6);
        chk("mid_ptr3", cdb, 3);
        reset = 1'b1; wr(3, 4'd5);
        chk("mid_hex0", hb0, BLK); chk("mid_hex2", hb2, BLK);
        chk("mid_ptr", cdb, 0);    chk("mid_fd", fdb, 0);
        reset = 1'b0;
        step(12);
        chk("post_hex0", hb0, D0); chk("post_hex3", hb3, D0); chk("post_fd", fdb, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
